// File: rtl/pattern_logger_pkg.sv
// Shared defaults, event layout and sizing helper for the pattern change logger.
package pattern_logger_pkg;

    localparam int DATA_W_DEF = 3;
    localparam int TS_W_DEF   = 16;
    localparam int CNT_W_DEF  = 16;
    localparam int DEPTH_DEF  = 8;

    typedef struct packed {
        logic [TS_W_DEF-1:0]   ts;
        logic [DATA_W_DEF-1:0] pat;
    } evt_t;

    // Level counter needs one extra bit to represent a completely full FIFO.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// First-word-fall-through FIFO with registered head output; a push into an
// empty FIFO becomes visible one cycle later (no bypass).
module sync_fwft_fifo
    import pattern_logger_pkg::*;
#(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_req_i,
    input  logic [WIDTH-1:0]          push_data_i,
    input  logic                      ready_i,
    output logic                      valid_o,
    output logic [WIDTH-1:0]          data_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      push_acc_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [LVL_W-1:0] r_level;
    logic [LVL_W-1:0] w_level_nxt;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_head_nxt;
    logic             w_pop;
    logic             w_push;

    assign valid_o    = (r_level != '0);
    assign w_pop      = valid_o && ready_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push     = push_req_i && ((r_level != LVL_W'(DEPTH)) || w_pop);
    assign push_acc_o = w_push;
    assign data_o     = r_dout;
    assign level_o    = r_level;

    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
        w_level_nxt  = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_W'(1);
            2'b01:   w_level_nxt = r_level - LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
        // The next head may be the entry being written this very cycle.
        if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
            w_head_nxt = push_data_i;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_dout   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            if (w_level_nxt != '0) begin
                r_dout <= w_head_nxt;
            end
        end
    end

endmodule

// File: rtl/pattern_change_logger.sv
// Synchronises the generator pattern bus, timestamps every value change and
// queues {ts, pattern} events for a valid/ready consumer.
module pattern_change_logger
    import pattern_logger_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TS_W   = TS_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        pat_i,
    input  logic                     en_i,
    output logic                     evt_valid_o,
    input  logic                     evt_ready_i,
    output logic [TS_W+DATA_W-1:0]   evt_data_o,
    output logic [CNT_W-1:0]         evt_count_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     overflow_o
);

    logic [DATA_W-1:0] r_s1;
    logic [DATA_W-1:0] r_s2;
    logic [DATA_W-1:0] r_prev;
    logic [TS_W-1:0]   r_ts;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              w_chg;
    logic              w_push_req;
    logic              w_push_acc;

    assign w_chg      = (r_s2 != r_prev);
    assign w_push_req = w_chg && en_i;

    // prev follows s2 even while logging is disabled, so re-enabling never
    // logs the value already present on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
            r_ts   <= '0;
        end else begin
            r_s1   <= pat_i;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_ts   <= r_ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_acc && (r_count != '1)) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_push_req && !w_push_acc) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sync_fwft_fifo #(
        .WIDTH (TS_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_req_i  (w_push_req),
        .push_data_i ({r_ts, r_s2}),
        .ready_i     (evt_ready_i),
        .valid_o     (evt_valid_o),
        .data_o      (evt_data_o),
        .level_o     (fifo_level_o),
        .push_acc_o  (w_push_acc)
    );

    assign evt_count_o = r_count;
    assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_pattern_change_logger.sv
// Bench for pattern_change_logger: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_pattern_change_logger;
    import pattern_logger_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  pat_i = 3'b000;
    logic        en_i = 1'b1;
    logic        evt_ready_i = 1'b0;
    logic        evt_valid_o;
    logic [18:0] evt_data_o;
    logic [15:0] evt_count_o;
    logic [3:0]  fifo_level_o;
    logic        overflow_o;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    pattern_change_logger dut (
        .clk          (clk),
        .rst          (rst),
        .pat_i        (pat_i),
        .en_i         (en_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_data_o   (evt_data_o),
        .evt_count_o  (evt_count_o),
        .fifo_level_o (fifo_level_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    // Reference model: the history of sampled bus values, a queue of events,
    // and plain counters.
    evt_t        mq[$];
    logic [2:0]  mhist[$];
    int unsigned mts;
    int unsigned mcount;
    bit          movf;
    evt_t        mlast;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mhist = '{3'b000, 3'b000, 3'b000};
            mts    = 0;
            mcount = 0;
            movf   = 1'b0;
            mlast  = '0;
        end else begin
            bit   pop;
            bit   req;
            evt_t e;
            pop   = (mq.size() > 0) && evt_ready_i;
            req   = (mhist[mhist.size()-2] != mhist[mhist.size()-3]) && en_i;
            e.ts  = mts[15:0];
            e.pat = mhist[mhist.size()-2];
            if (pop) void'(mq.pop_front());
            if (req) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(e);
                    if (mcount != 65535) mcount++;
                end else begin
                    movf = 1'b1;
                end
            end
            mhist.push_back(pat_i);
            if (mhist.size() > 3) void'(mhist.pop_front());
            mts = (mts + 1) & 32'h0000_FFFF;
            if (mq.size() > 0) mlast = mq[0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("valid", 32'(evt_valid_o), 32'(mq.size() > 0));
            check("level", 32'(fifo_level_o), 32'(mq.size()));
            check("count", 32'(evt_count_o), 32'(mcount));
            check("overflow", 32'(overflow_o), 32'(movf));
            check("data", 32'(evt_data_o), 32'(mlast));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Release lands just after a falling edge, so the next rising edge is edge 0 (ts=0).
    task automatic do_reset(input logic [2:0] p);
        @(negedge clk);
        #1 rst = 1'b1;
        pat_i = p;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // Idle bus: nothing logged.
        en_i = 1'b1; evt_ready_i = 1'b0;
        do_reset(3'b000);
        chk_en = 1'b1;
        tick(50);
        check("idle_valid", 32'(evt_valid_o), 32'd0);
        check("idle_count", 32'(evt_count_o), 32'd0);

        // Single change before edge 10, pushed at edge 12.
        do_reset(3'b000);
        tick(10);
        pat_i = 3'b101;
        tick(3);
        check("first_valid", 32'(evt_valid_o), 32'd1);
        check("first_data", 32'(evt_data_o), 32'({16'd12, 3'b101}));
        check("first_level", 32'(fifo_level_o), 32'd1);
        check("first_count", 32'(evt_count_o), 32'd1);

        // Ten changes into an 8-deep FIFO with no consumer.
        do_reset(3'b000);
        for (int i = 0; i < 10; i++) begin
            pat_i = pat_i + 3'd1;
            tick(4);
        end
        check("full_level", 32'(fifo_level_o), 32'd8);
        check("full_count", 32'(evt_count_o), 32'd8);
        check("full_ovf", 32'(overflow_o), 32'd1);
        check("full_head", 32'(evt_data_o), 32'({16'd2, 3'b001}));
        evt_ready_i = 1'b1;
        tick(10);
        evt_ready_i = 1'b0;
        check("drained_level", 32'(fifo_level_o), 32'd0);

        // Full FIFO, push coincides with a pop.
        do_reset(3'b000);
        for (int i = 0; i < 8; i++) begin
            pat_i = pat_i + 3'd1;
            tick(4);
        end
        pat_i = pat_i + 3'd1;
        tick(2);
        evt_ready_i = 1'b1;
        tick(1);
        evt_ready_i = 1'b0;
        check("swap_level", 32'(fifo_level_o), 32'd8);
        check("swap_ovf", 32'(overflow_o), 32'd0);
        check("swap_count", 32'(evt_count_o), 32'd9);

        // Changes while disabled are tracked but not logged.
        do_reset(3'b000);
        en_i = 1'b0;
        pat_i = 3'b001; tick(3);
        pat_i = 3'b010; tick(3);
        pat_i = 3'b001; tick(3);
        pat_i = 3'b010; tick(5);
        en_i = 1'b1;
        tick(5);
        check("en_quiet_count", 32'(evt_count_o), 32'd0);
        pat_i = 3'b111;
        tick(4);
        check("en_count", 32'(evt_count_o), 32'd1);
        check("en_level", 32'(fifo_level_o), 32'd1);
        check("en_pat", 32'(evt_data_o[2:0]), 32'(3'b111));

        // Asynchronous reset with events queued.
        do_reset(3'b000);
        for (int i = 1; i <= 3; i++) begin
            pat_i = 3'(i);
            tick(4);
        end
        check("pre_rst_level", 32'(fifo_level_o), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 32'(evt_valid_o), 32'd0);
        check("rst_level", 32'(fifo_level_o), 32'd0);
        check("rst_count", 32'(evt_count_o), 32'd0);
        check("rst_data", 32'(evt_data_o), 32'd0);
        pat_i = 3'b110;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        tick(3);
        check("post_rst_valid", 32'(evt_valid_o), 32'd1);
        check("post_rst_data", 32'(evt_data_o), 32'({16'd2, 3'b110}));
        check("post_rst_level", 32'(fifo_level_o), 32'd1);
        tick(5);
        check("post_rst_single", 32'(evt_count_o), 32'd1);

        // Randomised traffic: bursts that overflow, then a faster consumer.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 3) pat_i = 3'($urandom);
            en_i = ($urandom_range(0, 9) != 0);
            if (i < 1500) evt_ready_i = ($urandom_range(0, 3) == 0);
            else          evt_ready_i = ($urandom_range(0, 3) != 0);
            if (i == 2000) begin
                do_reset(3'($urandom));
            end
            tick(1);
        end
        evt_ready_i = 1'b1;
        tick(20);
        check("final_level", 32'(fifo_level_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
